// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register chain: stage actions and legal depth range.
package pipe_pkg;

    typedef enum logic [1:0] {
        ACT_ADVANCE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_STALL   = 2'd2,
        ACT_FLUSH   = 2'd3
    } pipe_act_e;

    localparam int DEPTH_MIN = 1;
    localparam int DEPTH_MAX = 8;

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Pipeline entry bundle (valid, control, data) carried between stages.
interface pipe_reg_chain_if #(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128
);
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, ctrl, data);
    modport slave  (input  valid, ctrl, data);
endinterface

// File: rtl/pipe_stage.sv
// One pipeline register stage: valid/ctrl/data registers plus decode of the chain-wide action.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int CTRL_W  = 8,
    parameter int DATA_W  = 128,
    parameter bit IS_HEAD = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  pipe_act_e         act,
    input  logic              prev_valid,
    input  logic [CTRL_W-1:0] prev_ctrl,
    input  logic [DATA_W-1:0] prev_data,
    output logic              valid_r,
    output logic [CTRL_W-1:0] ctrl_r,
    output logic [DATA_W-1:0] data_r
);

    logic              valid_s;
    logic [CTRL_W-1:0] ctrl_s;
    logic [DATA_W-1:0] data_s;

    // Next-state decode; an invalid entry always carries zero control.
    always_comb begin
        valid_s = valid_r;
        ctrl_s  = ctrl_r;
        data_s  = data_r;
        case (act)
            ACT_FLUSH: begin
                valid_s = 1'b0;
                ctrl_s  = '0;
            end
            ACT_STALL: begin
                valid_s = valid_r;
                ctrl_s  = ctrl_r;
            end
            ACT_BUBBLE: begin
                if (IS_HEAD) begin
                    valid_s = 1'b0;
                    ctrl_s  = '0;
                end else begin
                    valid_s = prev_valid;
                    ctrl_s  = prev_valid ? prev_ctrl : '0;
                    data_s  = prev_data;
                end
            end
            ACT_ADVANCE: begin
                valid_s = prev_valid;
                ctrl_s  = prev_valid ? prev_ctrl : '0;
                data_s  = prev_data;
            end
            default: begin
                valid_s = valid_r;
                ctrl_s  = ctrl_r;
            end
        endcase
    end

    // Stage registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_r <= 1'b0;
            ctrl_r  <= '0;
            data_r  <= '0;
        end else begin
            valid_r <= valid_s;
            ctrl_r  <= ctrl_s;
            data_r  <= data_s;
        end
    end

endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage pipeline register chain with stall, head bubble and flush.
// Optional event counters are built when PIPE_STATS_EN is defined.
module pipe_reg_chain
    import pipe_pkg::*;
#(
    parameter int CTRL_W = 8,
    parameter int DATA_W = 128,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              bubble_i,
    input  logic              flush_i,
    pipe_reg_chain_if.slave   in_bus,
    pipe_reg_chain_if.master  out_bus,
    output logic [DEPTH-1:0]  stage_valid_o
`ifdef PIPE_STATS_EN
    ,
    input  logic              clr_stats_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

    pipe_act_e         act_s;
    logic              valid_s [DEPTH];
    logic [CTRL_W-1:0] ctrl_s  [DEPTH];
    logic [DATA_W-1:0] data_s  [DEPTH];

    // One action per edge: flush beats stall beats bubble beats advance.
    always_comb begin
        act_s = ACT_ADVANCE;
        if (flush_i) begin
            act_s = ACT_FLUSH;
        end else if (stall_i) begin
            act_s = ACT_STALL;
        end else if (bubble_i) begin
            act_s = ACT_BUBBLE;
        end else begin
            act_s = ACT_ADVANCE;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        if (k == 0) begin : g_head
            pipe_stage #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .IS_HEAD(1'b1)
            ) u_stage (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .act       (act_s),
                .prev_valid(in_bus.valid),
                .prev_ctrl (in_bus.ctrl),
                .prev_data (in_bus.data),
                .valid_r   (valid_s[k]),
                .ctrl_r    (ctrl_s[k]),
                .data_r    (data_s[k])
            );
        end else begin : g_body
            pipe_stage #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W),
                .IS_HEAD(1'b0)
            ) u_stage (
                .clk_i     (clk_i),
                .rst_i     (rst_i),
                .act       (act_s),
                .prev_valid(valid_s[k-1]),
                .prev_ctrl (ctrl_s[k-1]),
                .prev_data (data_s[k-1]),
                .valid_r   (valid_s[k]),
                .ctrl_r    (ctrl_s[k]),
                .data_r    (data_s[k])
            );
        end
        assign stage_valid_o[k] = valid_s[k];
    end

    assign out_bus.valid = valid_s[DEPTH-1];
    assign out_bus.ctrl  = ctrl_s[DEPTH-1];
    assign out_bus.data  = data_s[DEPTH-1];

`ifdef PIPE_STATS_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] bubble_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Saturating event counters; a clear overrides any same-cycle increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_r  <= '0;
            bubble_cnt_r <= '0;
            flush_cnt_r  <= '0;
        end else if (clr_stats_i) begin
            stall_cnt_r  <= '0;
            bubble_cnt_r <= '0;
            flush_cnt_r  <= '0;
        end else begin
            stall_cnt_r  <= (act_s == ACT_STALL)  ? sat_inc(stall_cnt_r)  : stall_cnt_r;
            bubble_cnt_r <= (act_s == ACT_BUBBLE) ? sat_inc(bubble_cnt_r) : bubble_cnt_r;
            flush_cnt_r  <= (act_s == ACT_FLUSH)  ? sat_inc(flush_cnt_r)  : flush_cnt_r;
        end
    end

    assign stall_cnt_o  = stall_cnt_r;
    assign bubble_cnt_o = bubble_cnt_r;
    assign flush_cnt_o  = flush_cnt_r;
`endif

endmodule

// File: doc/pipe_reg_chain.md
# pipe_reg_chain

Parametrised pipeline register chain, the generalised successor to the per-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) of the five-stage core. Carries a control bundle and a data bundle through DEPTH register stages with a valid bit per stage. Supports hold (stall), bubble insertion at the head, and full flush. Sits between any two pipeline stages and is driven by the hazard-detection unit.

## Interface
- CTRL_W, 8: control bundle width (WB/M/EX fields); zeroed on bubble/flush.
- DATA_W, 128: data bundle width (PC, register data, sign-extend, register addresses); never zeroed except by reset.
- DEPTH, 1: number of register stages; legal range 1..8.
- CNT_W, 16: statistics counter width (only with PIPE_STATS_EN).

- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- stall_i  in  1  hold every stage.
- bubble_i  in  1  load a bubble into stage 0; downstream stages advance.
- flush_i  in  1  invalidate every stage.
- valid_i  in  1  incoming entry is a real instruction.
- ctrl_i  in  CTRL_W  incoming control bundle.
- data_i  in  DATA_W  incoming data bundle.
- valid_o  out  1  valid of last stage.
- ctrl_o  out  CTRL_W  control of last stage.
- data_o  out  DATA_W  data of last stage.
- stage_valid_o  out  DEPTH  valid bit of every stage, bit 0 = head; for hazard/forwarding logic.
- clr_stats_i  in  1  synchronous clear of counters (PIPE_STATS_EN only).
- stall_cnt_o, bubble_cnt_o, flush_cnt_o  out  CNT_W each  event counters (PIPE_STATS_EN only).

## Operation
- Per edge, exactly one action, priority flush > stall > bubble > advance.
- Flush: every stage valid=0, ctrl=0; data registers hold.
- Stall: every stage (valid, ctrl, data) holds.
- Bubble: stage 0 valid=0, ctrl=0, data holds; stage k>0 loads stage k-1.
- Advance: stage 0 loads valid_i, ctrl_i, data_i; stage k>0 loads stage k-1.
- A stage with valid=0 always presents ctrl=0, so a bubble never writes registers or memory downstream.
- valid_i=0 during advance is loaded as-is; ctrl_i is then forced to 0 at capture.
- Counters: stall_cnt increments on cycles where stall_i=1 and flush_i=0; bubble_cnt on bubble actions that take effect; flush_cnt on flush_i=1. All saturate at 2^CNT_W-1, never wrap. clr_stats_i zeroes all three and wins over a same-cycle increment.

## Timing
- Reset (asynchronous assert, release synchronous to clk_i): all valid, ctrl, data registers = 0; valid_o=0, ctrl_o=0, data_o=0, stage_valid_o=0, all counters = 0. Reset mid-stall or mid-flush discards everything.
- Latency valid_i to valid_o: DEPTH cycles when no stall/flush; each stall cycle adds one.
- Outputs are registered; no combinational path from any input to any output.
- Simultaneous flush_i and stall_i: flush happens, stall_cnt unchanged, flush_cnt +1.
- Simultaneous stall_i and bubble_i: hold; bubble is not counted and not deferred.
- DEPTH=1: bubble and advance both act only on stage 0; data_o follows stage 0.

## Configuration
- PIPE_STATS_EN defined: clr_stats_i and the three counters exist and behave as above.
- PIPE_STATS_EN undefined: those ports and registers are absent; datapath behaviour is identical.

## Structure
- Shared package pipe_pkg: stage action enumeration (ACT_ADVANCE, ACT_BUBBLE, ACT_STALL, ACT_FLUSH) and the DEPTH legal-range constants.
- One sub-module pipe_stage: single stage with valid/ctrl/data registers and the action decode; pipe_reg_chain instantiates DEPTH of them plus the optional counters.

## Test plan
- Reset then advance, DEPTH=3: valid_i=1, ctrl_i=8'hA5, data_i=128'h1234 at cycle 0 -> valid_o=1, ctrl_o=8'hA5, data_o=128'h1234 after exactly 3 edges; stage_valid_o walks 001, 011, 111 under continuous valid_i.
- Stall for 2 cycles mid-flight -> all stages hold, output arrives 2 cycles later; stall_cnt_o=2.
- Bubble with stage contents {A,B,C} -> next edge stages {bubble,A,B}, ctrl of head = 0, data of head unchanged; bubble_cnt_o=1.
- flush_i and stall_i together with 3 valid stages -> stage_valid_o=000, all ctrl=0, data unchanged; flush_cnt_o=1, stall_cnt_o=0.
- Saturation, CNT_W=4: stall_i held 20 cycles -> stall_cnt_o=15; clr_stats_i with stall_i=1 -> 0 next edge.
- Asynchronous rst_i asserted between edges during a stall -> outputs 0 immediately, no edge needed; build without PIPE_STATS_EN passes first four scenarios identically.
